// File: rtl/rr_mem_arbiter_n.sv
// rr_mem_arbiter_n: N-channel round-robin arbiter in front of one single-port
// synchronous RAM. The grant is registered, all RAM-side data is muxed from the
// granted channel, reads produce a per-channel valid one cycle after the access,
// and a watchdog revokes over-long grants and locks the channel out until it
// releases its request.
//
// Handshake: a channel raises req[i] and holds it for the whole burst. A
// transfer happens on every cycle where ack[i]=1. Dropping req[i] ends the burst;
// ack[i] follows req[i] combinationally inside a grant, so there is no
// transfer on the cycle req[i] is low.
module rr_mem_arbiter_n #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int WD_WIDTH   = 6,
  parameter int WD_LIMIT   = 63
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CH-1:0]              req,
  output logic [NUM_CH-1:0]              ack,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   ch_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_wrdata,
  input  logic [NUM_CH-1:0]              ch_rdwrn,
  output logic [DATA_WIDTH-1:0]          ch_rddata,
  output logic [NUM_CH-1:0]              ch_rvalid,
  output logic [NUM_CH-1:0]              timeout,
  output logic                           mem_en,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [DATA_WIDTH-1:0]          mem_wrdata,
  output logic                           mem_rdwrn,
  input  logic [DATA_WIDTH-1:0]          mem_rddata,
  output logic                           dbg_state
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam bit WD_ON = (WD_LIMIT != 0);
  localparam logic [WD_WIDTH-1:0] WD_LIM = WD_WIDTH'(WD_LIMIT);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_CH - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t              state, state_n;
  logic [IDX_W-1:0]    grant_idx, grant_n;
  logic [IDX_W-1:0]    last_ptr, last_n;
  logic [WD_WIDTH-1:0] wd_cnt, wd_n;
  logic [NUM_CH-1:0]   blocked, blocked_n;
  logic [NUM_CH-1:0]   rvalid_q;

  logic [NUM_CH-1:0]   elig;
  logic [NUM_CH-1:0]   g_oh;
  logic [NUM_CH-1:0]   arb_set;
  logic                req_g;
  logic                expire;
  logic                win_found;
  logic [IDX_W-1:0]    win_idx;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_CH];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign addr_arr[i]  = ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[i] = ch_wrdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign elig      = req & ~blocked;
  assign req_g     = req[grant_idx];
  assign dbg_state = (state == GRANT);
  assign ch_rvalid = rvalid_q;
  assign ch_rddata = mem_rddata;

  // One-hot of the current grant; while granted, the holder is excluded from
  // re-arbitration (it is either releasing or being revoked).
  always_comb begin
    g_oh = '0;
    g_oh[grant_idx] = 1'b1;
    arb_set = (state == GRANT) ? (elig & ~g_oh) : elig;
  end

  // Round-robin search starting just after the last-served channel.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = IDX_W'((int'(last_ptr) + k) % NUM_CH);
      if (!win_found && arb_set[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state, ack, watchdog and timeout decisions.
  always_comb begin
    state_n = state;
    grant_n = grant_idx;
    last_n  = last_ptr;
    wd_n    = wd_cnt;
    ack     = '0;
    timeout = '0;
    expire  = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_n = GRANT;
          grant_n = win_idx;
          last_n  = win_idx;
          wd_n    = '0;
        end
      end
      GRANT: begin
        if (req_g && (!WD_ON || (wd_cnt < WD_LIM))) begin
          ack[grant_idx] = 1'b1;
          wd_n = wd_cnt + 1'b1;
        end else begin
          // Either a release (req low) or a watchdog expiry (req still high).
          if (req_g) begin
            timeout[grant_idx] = 1'b1;
            expire = 1'b1;
          end
          wd_n = '0;
          if (win_found) begin
            grant_n = win_idx;
            last_n  = win_idx;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A revoked channel stays locked out until it drops its request.
  always_comb begin
    blocked_n = (blocked | (expire ? g_oh : '0)) & req;
  end

  // RAM port mux; idle values whenever nobody is acknowledged.
  always_comb begin
    mem_en     = |ack;
    mem_addr   = '0;
    mem_wrdata = '0;
    mem_rdwrn  = 1'b1;
    if (mem_en) begin
      mem_addr   = addr_arr[grant_idx];
      mem_wrdata = wdata_arr[grant_idx];
      mem_rdwrn  = ch_rdwrn[grant_idx];
    end
  end

  // Registered arbiter state and the one-cycle-delayed read valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant_idx <= '0;
      last_ptr  <= LAST_RST;
      wd_cnt    <= '0;
      blocked   <= '0;
      rvalid_q  <= '0;
    end else begin
      state     <= state_n;
      grant_idx <= grant_n;
      last_ptr  <= last_n;
      wd_cnt    <= wd_n;
      blocked   <= blocked_n;
      rvalid_q  <= ack & ch_rdwrn;
    end
  end

endmodule

// File: tb/tb_rr_mem_arbiter_n.sv
// tb_rr_mem_arbiter_n: directed bench for rr_mem_arbiter_n. Three instances
// share the stimulus: u_dut (WD_LIMIT=63, with a RAM model), u_wd5 (WD_LIMIT=5)
// and u_wd0 (watchdog disabled). Inputs change 1 ns after the rising edge and
// outputs are sampled 2 ns after it.
module tb_rr_mem_arbiter_n;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 8;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*AW-1:0] ch_addr;
  logic [N*DW-1:0] ch_wrdata;
  logic [N-1:0]    ch_rdwrn;
  logic [DW-1:0]   zero_data;

  logic [N-1:0]  ack_a, rv_a, to_a;
  logic [DW-1:0] rd_a, mwd_a, mrd_a;
  logic [AW-1:0] madr_a;
  logic          men_a, mrw_a, dbg_a;

  logic [N-1:0]  ack_b, rv_b, to_b;
  logic [DW-1:0] rd_b, mwd_b;
  logic [AW-1:0] madr_b;
  logic          men_b, mrw_b, dbg_b;

  logic [N-1:0]  ack_c, rv_c, to_c;
  logic [DW-1:0] rd_c, mwd_c;
  logic [AW-1:0] madr_c;
  logic          men_c, mrw_c, dbg_c;

  int n_checks = 0;
  int n_fail   = 0;
  int viol     = 0;

  rr_mem_arbiter_n #(.NUM_CH(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WD_WIDTH(6), .WD_LIMIT(63)) u_dut (
    .clk(clk), .reset(reset), .req(req), .ack(ack_a), .ch_addr(ch_addr),
    .ch_wrdata(ch_wrdata), .ch_rdwrn(ch_rdwrn), .ch_rddata(rd_a), .ch_rvalid(rv_a),
    .timeout(to_a), .mem_en(men_a), .mem_addr(madr_a), .mem_wrdata(mwd_a),
    .mem_rdwrn(mrw_a), .mem_rddata(mrd_a), .dbg_state(dbg_a));

  rr_mem_arbiter_n #(.NUM_CH(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WD_WIDTH(6), .WD_LIMIT(5)) u_wd5 (
    .clk(clk), .reset(reset), .req(req), .ack(ack_b), .ch_addr(ch_addr),
    .ch_wrdata(ch_wrdata), .ch_rdwrn(ch_rdwrn), .ch_rddata(rd_b), .ch_rvalid(rv_b),
    .timeout(to_b), .mem_en(men_b), .mem_addr(madr_b), .mem_wrdata(mwd_b),
    .mem_rdwrn(mrw_b), .mem_rddata(zero_data), .dbg_state(dbg_b));

  rr_mem_arbiter_n #(.NUM_CH(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WD_WIDTH(6), .WD_LIMIT(0)) u_wd0 (
    .clk(clk), .reset(reset), .req(req), .ack(ack_c), .ch_addr(ch_addr),
    .ch_wrdata(ch_wrdata), .ch_rdwrn(ch_rdwrn), .ch_rddata(rd_c), .ch_rvalid(rv_c),
    .timeout(to_c), .mem_en(men_c), .mem_addr(madr_c), .mem_wrdata(mwd_c),
    .mem_rdwrn(mrw_c), .mem_rddata(zero_data), .dbg_state(dbg_c));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM model for u_dut.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (reset) mrd_a <= '0;
    else if (men_a) begin
      if (!mrw_a) ram[madr_a] <= mwd_a;
      else        mrd_a <= ram[madr_a];
    end
  end

  // Exclusivity invariants on every instance.
  always @(negedge clk) begin
    if (!reset) begin
      if ($countones(ack_a) > 1 || $countones(to_a) > 1 || (ack_a & to_a) != 0) viol++;
      if ($countones(ack_b) > 1 || $countones(to_b) > 1 || (ack_b & to_b) != 0) viol++;
      if ($countones(ack_c) > 1 || $countones(to_c) > 1 || (ack_c & to_c) != 0) viol++;
    end
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    ch_rdwrn = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Advance to 1 ns after the next rising edge (drive point).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    int r = 0;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int cnt [N];
    int order [N];
    int order_n, first, last, mem_cnt, idle_cnt, ch, n1, nto;
    logic [N-1:0] drop;
    logic [15:0] order_word;

    reset = 1'b1; req = '0; ch_addr = '0; ch_wrdata = '0; ch_rdwrn = '0; zero_data = '0;

    // Reset state.
    do_reset();
    #1;
    check("rst_ack",    ack_a, 0);
    check("rst_rvalid", rv_a, 0);
    check("rst_timeout", to_a, 0);
    check("rst_mem_en", men_a, 0);
    check("rst_mem_addr", madr_a, 0);
    check("rst_mem_wrdata", mwd_a, 0);
    check("rst_mem_rdwrn", mrw_a, 1);
    check("rst_rddata", rd_a, 0);
    check("rst_state", dbg_a, 0);

    // 1: all four request, each drops after 3 acks.
    for (int i = 0; i < N; i++) begin cnt[i] = 0; order[i] = 0; end
    order_n = 0; first = -1; last = -1; mem_cnt = 0; idle_cnt = 0; drop = '0;
    req = 4'b1111;
    for (int c = 0; c < 24; c++) begin
      step();
      req = req & ~drop;
      drop = '0;
      #1;
      if (ack_a != 0) begin
        ch = oh_idx(ack_a);
        if (order_n == 0 || order[order_n-1] != ch) begin
          if (order_n < N) order[order_n] = ch;
          order_n++;
        end
        cnt[ch]++;
        if (cnt[ch] == 3) drop[ch] = 1'b1;
        if (first < 0) first = c;
        last = c;
      end
      if (men_a) mem_cnt++;
      if (first >= 0 && req != 0 && !dbg_a) idle_cnt++;
    end
    order_word = '0;
    for (int i = 0; i < N; i++) order_word[i*4 +: 4] = 4'(order[i]);
    check("t1_first_ack_latency", first, 0);
    check("t1_grants", order_n, 4);
    check("t1_order", order_word, 16'h3210);
    for (int i = 0; i < N; i++) check($sformatf("t1_acks_ch%0d", i), cnt[i], 3);
    check("t1_mem_en_cycles", mem_cnt, 12);
    check("t1_span", last - first, 14);
    check("t1_no_idle_between", idle_cnt, 0);

    // 2: channel 2 writes 0x3C to 0x0A5 twice, then reads it back.
    do_reset();
    ch_addr[2*AW +: AW] = 12'h0A5;
    ch_wrdata[2*DW +: DW] = 8'h3C;
    ch_rdwrn = 4'b0000;
    req = 4'b0100;
    step(); #1;
    check("t2_w1_ack", ack_a, 4'b0100);
    check("t2_w1_addr", madr_a, 12'h0A5);
    check("t2_w1_rdwrn", mrw_a, 0);
    check("t2_w1_wrdata", mwd_a, 8'h3C);
    check("t2_w1_rvalid", rv_a, 0);
    step(); #1;
    check("t2_w2_ack", ack_a, 4'b0100);
    step();
    ch_rdwrn = 4'b0100;
    #1;
    check("t2_rd_ack", ack_a, 4'b0100);
    check("t2_rd_rdwrn", mrw_a, 1);
    step();
    req = 4'b0000;
    #1;
    check("t2_rvalid", rv_a, 4'b0100);
    check("t2_rddata", rd_a, 8'h3C);
    check("t2_idle_mem_en", men_a, 0);
    check("t2_idle_addr", madr_a, 0);
    check("t2_idle_rdwrn", mrw_a, 1);
    step(); #1;
    check("t2_rvalid_clear", rv_a, 0);
    ch_rdwrn = '0;

    // 3: WD_LIMIT=5, channel 1 holds, channel 3 waits.
    do_reset();
    req = 4'b1010;
    n1 = 0;
    for (int c = 0; c < 5; c++) begin
      step(); #1;
      if (ack_b == 4'b0010) n1++;
    end
    check("t3_ch1_acks", n1, 5);
    step(); #1;
    check("t3_timeout", to_b, 4'b0010);
    check("t3_no_ack_on_timeout", ack_b, 0);
    step(); #1;
    check("t3_ch3_next", ack_b, 4'b1000);
    check("t3_timeout_pulse", to_b, 0);
    step();
    step();
    req = 4'b0010;
    #1;
    n1 = 0;
    for (int c = 0; c < 4; c++) begin
      step(); #1;
      if (ack_b != 0 || to_b != 0) n1++;
    end
    check("t3_ch1_locked_out", n1, 0);
    step();
    req = 4'b0000;
    step();
    req = 4'b0010;
    #1;
    check("t3_reassert_idle", ack_b, 0);
    step(); #1;
    check("t3_ch1_served_again", ack_b, 4'b0010);

    // 4: last grant was 3, then 0 and 2 rise together.
    do_reset();
    req = 4'b1000;
    step(); #1;
    check("t4_ch3_ack", ack_a, 4'b1000);
    step();
    req = 4'b0000;
    step();
    req = 4'b0101;
    #1;
    check("t4_idle_no_ack", ack_a, 0);
    step(); #1;
    check("t4_first_ch0", ack_a, 4'b0001);
    step();
    req = 4'b0100;
    #1;
    check("t4_release_no_ack", ack_a, 0);
    step(); #1;
    check("t4_then_ch2", ack_a, 4'b0100);
    step();
    req = 4'b0000;

    // 5: reset during channel 0's 4th ack cycle.
    do_reset();
    req = 4'b0001;
    step(); step(); step(); step();
    #1;
    check("t5_4th_ack", ack_a, 4'b0001);
    reset = 1'b1;
    step(); #1;
    check("t5_rst_ack", ack_a, 0);
    check("t5_rst_mem_en", men_a, 0);
    check("t5_rst_timeout", to_a, 0);
    check("t5_rst_rvalid", rv_a, 0);
    reset = 1'b0;
    req = 4'b1111;
    step(); #1;
    check("t5_post_rst_ch0", ack_a, 4'b0001);
    step();
    req = 4'b0000;

    // 6: watchdog disabled, channel 1 holds for 200 cycles.
    do_reset();
    req = 4'b0010;
    n1 = 0; nto = 0;
    for (int c = 0; c < 200; c++) begin
      step(); #1;
      if (ack_c == 4'b0010) n1++;
      if (to_c != 0) nto++;
    end
    check("t6_ack_cycles", n1, 200);
    check("t6_no_timeout", nto, 0);
    step();
    req = 4'b0000;
    step(); step();

    check("invariants", viol, 0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
